// File: rtl/fuzzy_pkg.sv
// Shared types and Q1.15 helpers for the fuzzy rule-base evaluator.
package fuzzy_pkg;

  typedef logic [15:0] q15_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rule_state_e;

  function automatic q15_t q15_min(input q15_t a, input q15_t b);
    return (a < b) ? a : b;
  endfunction

  // Product AND; both operands are at most 32767, so the product fits in 30 bits.
  function automatic q15_t q15_mul_shr15(input q15_t a, input q15_t b);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    return p[30:15];
  endfunction

  // Percent consequent to Q1.15: clamp at 100 %, then saturate 1.0 to 32767.
  function automatic q15_t g_percent_to_q15(input logic [7:0] g);
    logic [7:0]  gc;
    logic [22:0] num;
    logic [22:0] q;
    gc  = (g > 8'd100) ? 8'd100 : g;
    num = {gc, 15'd0};
    q   = num / 23'd100;
    if (q > 23'd32767) return 16'h7fff;
    return q[15:0];
  endfunction

endpackage

// File: rtl/fuzzy_rule_mac.sv
// Multiply-accumulate for rule weights: product register, then the S_w / S_wg accumulators.
module fuzzy_rule_mac
  import fuzzy_pkg::*;
#(
  parameter int unsigned SW_W  = 20,
  parameter int unsigned SWG_W = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  q15_t             w,
  input  q15_t             gq,
  output logic [SW_W-1:0]  acc_w,
  output logic [SWG_W-1:0] acc_wg
);

  logic             p_v_q;
  q15_t             p_w_q;
  logic [31:0]      p_q;
  logic [SW_W-1:0]  acc_w_q;
  logic [SWG_W-1:0] acc_wg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v_q    <= 1'b0;
      p_w_q    <= '0;
      p_q      <= '0;
      acc_w_q  <= '0;
      acc_wg_q <= '0;
    end else if (clr) begin
      p_v_q    <= 1'b0;
      p_w_q    <= '0;
      p_q      <= '0;
      acc_w_q  <= '0;
      acc_wg_q <= '0;
    end else begin
      p_v_q <= en;
      p_w_q <= w;
      p_q   <= {16'd0, w} * {16'd0, gq};
      if (p_v_q) begin
        acc_w_q  <= acc_w_q + SW_W'(p_w_q);
        acc_wg_q <= acc_wg_q + SWG_W'(p_q);
      end
    end
  end

  assign acc_w  = acc_w_q;
  assign acc_wg = acc_wg_q;

endmodule

// File: rtl/fuzzy_rules_seq.sv
// Sequential fuzzy rule-base evaluator: one rule per cycle into a shared MAC, producing S_w and S_wg.
module fuzzy_rules_seq
  import fuzzy_pkg::*;
#(
  parameter int unsigned N_T  = 3,
  parameter int unsigned N_DT = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [16*N_T-1:0]                          mu_t,
  input  logic [16*N_DT-1:0]                         mu_dt,
  input  logic [8*N_T*N_DT-1:0]                      g_tab,
  input  logic [N_T*N_DT-1:0]                        rule_en,
  input  logic                                       and_mode,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [16+$clog2(N_T*N_DT)-1:0]             S_w,
  output logic [30+$clog2(N_T*N_DT)-1:0]             S_wg,
  output logic                                       none_fired
);

  localparam int unsigned N_RULES = N_T * N_DT;
  localparam int unsigned SW_W    = 16 + $clog2(N_RULES);
  localparam int unsigned SWG_W   = 30 + $clog2(N_RULES);
  localparam int unsigned RW      = $clog2(N_RULES + 1);

  rule_state_e state_q, state_d;
  logic [RW-1:0] r_q;

  logic [16*N_T-1:0]     mu_t_q;
  logic [16*N_DT-1:0]    mu_dt_q;
  logic [8*N_RULES-1:0]  g_q;
  logic [N_RULES-1:0]    en_q;
  logic                  mode_q;

  q15_t s1_w_q, s1_gq_q;
  logic s1_v_q;
  q15_t w_c, gq_c;

  logic accept, issue;

  assign accept = in_valid && (state_q == IDLE);
  assign issue  = (state_q == RUN) && (r_q < RW'(N_RULES));

  // Operand mux: constant indices per rule so only the rule compare is dynamic.
  always_comb begin
    w_c  = '0;
    gq_c = '0;
    for (int r = 0; r < N_RULES; r++) begin
      if (r_q == RW'(r) && en_q[r]) begin
        w_c  = mode_q ? q15_mul_shr15(mu_t_q[16*(r/N_DT) +: 16], mu_dt_q[16*(r%N_DT) +: 16])
                      : q15_min(mu_t_q[16*(r/N_DT) +: 16], mu_dt_q[16*(r%N_DT) +: 16]);
        gq_c = g_percent_to_q15(g_q[8*r +: 8]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      // One extra RUN cycle after the last issue lets the product register fill.
      RUN:     if (r_q == RW'(N_RULES)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      mu_t_q  <= '0;
      mu_dt_q <= '0;
      g_q     <= '0;
      en_q    <= '0;
      mode_q  <= 1'b0;
      s1_w_q  <= '0;
      s1_gq_q <= '0;
      s1_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mu_t_q  <= mu_t;
        mu_dt_q <= mu_dt;
        g_q     <= g_tab;
        en_q    <= rule_en;
        mode_q  <= and_mode;
        r_q     <= '0;
        s1_v_q  <= 1'b0;
      end else if (issue) begin
        s1_w_q  <= w_c;
        s1_gq_q <= gq_c;
        s1_v_q  <= 1'b1;
        r_q     <= r_q + RW'(1);
      end else begin
        s1_v_q  <= 1'b0;
      end
    end
  end

  fuzzy_rule_mac #(
    .SW_W  (SW_W),
    .SWG_W (SWG_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (s1_v_q),
    .w      (s1_w_q),
    .gq     (s1_gq_q),
    .acc_w  (S_w),
    .acc_wg (S_wg)
  );

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign none_fired = out_valid && (S_w == '0);

endmodule

// File: tb/tb_fuzzy_rules_seq.sv
// Directed self-checking bench for fuzzy_rules_seq (3x3 rule grid).
module tb_fuzzy_rules_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] mu_t;
  logic [47:0] mu_dt;
  logic [71:0] g_tab;
  logic [8:0]  rule_en;
  logic        and_mode;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] S_w;
  logic [33:0] S_wg;
  logic        none_fired;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [19:0] hold_w;
  logic [33:0] hold_wg;

  always #5 clk = ~clk;

  fuzzy_rules_seq #(
    .N_T  (3),
    .N_DT (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mu_t       (mu_t),
    .mu_dt      (mu_dt),
    .g_tab      (g_tab),
    .rule_en    (rule_en),
    .and_mode   (and_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .S_w        (S_w),
    .S_wg       (S_wg),
    .none_fired (none_fired)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [47:0] mt, input logic [47:0] md, input logic [71:0] gt,
                       input logic [8:0] en, input logic mode);
    mu_t = mt; mu_dt = md; g_tab = gt; rule_en = en; and_mode = mode;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is seen.
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 n++;
      if (out_valid) break;
    end
  endtask

  task automatic finish_ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("ack_out_valid_low", 64'(out_valid), 64'd0);
    check("ack_in_ready_high", 64'(in_ready), 64'd1);
  endtask

  task automatic result(input string tag, input logic [63:0] ew, input logic [63:0] ewg,
                        input logic enf);
    check({tag, "_latency"}, 64'(cyc), 64'd11);
    check({tag, "_S_w"}, 64'(S_w), ew);
    check({tag, "_S_wg"}, 64'(S_wg), ewg);
    check({tag, "_none_fired"}, 64'(none_fired), 64'(enf));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mu_t = '0; mu_dt = '0; g_tab = '0; rule_en = '0; and_mode = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_S_w", 64'(S_w), 64'd0);
    check("rst_S_wg", 64'(S_wg), 64'd0);
    check("rst_none_fired", 64'(none_fired), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Single rule (t0, dt1) fires in min mode.
    start({16'd0, 16'd0, 16'd32767}, {16'd0, 16'd16384, 16'd0}, {9{8'd50}}, 9'h1ff, 1'b0);
    wait_done(cyc);
    result("single_min", 64'd16384, 64'd268435456, 1'b0);
    check("done_in_ready_low", 64'(in_ready), 64'd0);
    finish_ack();

    // Product AND with g = 100 clamped to 32767.
    start({16'd0, 16'd0, 16'd16384}, {16'd0, 16'd16384, 16'd0}, {9{8'd100}}, 9'h1ff, 1'b1);
    wait_done(cyc);
    result("product", 64'd8192, 64'd268427264, 1'b0);
    finish_ack();

    // Full scale with g clamp; inputs scrambled during RUN must not matter.
    start({3{16'd32767}}, {3{16'd32767}}, {9{8'd150}}, 9'h1ff, 1'b0);
    mu_t = '0; mu_dt = 48'h1234_5678_9abc; g_tab = '0; rule_en = '0; and_mode = 1'b1;
    wait_done(cyc);
    result("full_scale", 64'd294903, 64'd9663086601, 1'b0);
    hold_w = S_w; hold_wg = S_wg;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      mu_t = 48'(k);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_S_w_stable", 64'(S_w), 64'(hold_w));
      check("bp_S_wg_stable", 64'(S_wg), 64'(hold_wg));
    end
    in_valid = 1'b0;
    finish_ack();

    // All rules masked.
    start({3{16'd32767}}, {3{16'd32767}}, {9{8'd150}}, 9'h000, 1'b0);
    wait_done(cyc);
    result("mask_none", 64'd0, 64'd0, 1'b1);
    finish_ack();

    // Only the centre rule enabled.
    start({3{16'd32767}}, {3{16'd32767}}, {9{8'd150}}, 9'h010, 1'b0);
    wait_done(cyc);
    result("mask_rule4", 64'd32767, 64'd1073676289, 1'b0);
    finish_ack();

    // Smallest nonzero consequent: g = 1 -> 327.
    start({3{16'd32767}}, {3{16'd32767}}, {{8{8'd150}}, 8'd1}, 9'h001, 1'b0);
    wait_done(cyc);
    result("g_one", 64'd32767, 64'd10714809, 1'b0);
    finish_ack();

    // Product of full-scale operands truncates to 32766.
    start({3{16'd32767}}, {3{16'd32767}}, {9{8'd150}}, 9'h1ff, 1'b1);
    wait_done(cyc);
    result("product_full", 64'd294894, 64'd9662791698, 1'b0);
    finish_ack();

    // Reset while rule 4 is being issued.
    start({3{16'd32767}}, {3{16'd32767}}, {9{8'd150}}, 9'h1ff, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_S_w", 64'(S_w), 64'd0);
    check("midrst_S_wg", 64'(S_wg), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_none_fired", 64'(none_fired), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    start({16'd0, 16'd0, 16'd32767}, {16'd0, 16'd16384, 16'd0}, {9{8'd50}}, 9'h1ff, 1'b0);
    wait_done(cyc);
    result("after_rst", 64'd16384, 64'd268435456, 1'b0);
    finish_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
